// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I core; TRAP halts on illegal opcodes.
// Latency (zero-wait memory): OP/OPIMM/LUI/AUIPC/JAL/JALR/STORE 4 cycles, LOAD 5, BRANCH 3; each mem_ready wait adds 1.
// Backpressure: FETCH/MEM hold request and address until mem_ready; define MEM_TIMEOUT_EN to trap after MEM_TIMEOUT waits.
module rv32i_mc_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OC_NONE, OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BRANCH,
        OC_LOAD, OC_STORE, OC_OPIMM, OC_SHIFT, OC_OP, OC_ILLEGAL
    } opclass_t;

    state_t   state_q, state_d;
    opclass_t opc_q, opc_dec;
    logic     wait_mem, timeout;
    logic     unused_ir_bits;

    assign unused_ir_bits = ^{ir[31:15], ir[14]};
    assign state          = state_q;
    assign wait_mem       = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;

    // funct3 001/101 (SLLI/SRLI/SRAI) share ir[13:12]==01 and take the shamt immediate
    always_comb begin
        opc_dec = OC_ILLEGAL;
        case (ir[6:0])
            7'b0110111: opc_dec = OC_LUI;
            7'b0010111: opc_dec = OC_AUIPC;
            7'b1101111: opc_dec = OC_JAL;
            7'b1100111: opc_dec = OC_JALR;
            7'b1100011: opc_dec = OC_BRANCH;
            7'b0000011: opc_dec = OC_LOAD;
            7'b0100011: opc_dec = OC_STORE;
            7'b0010011: opc_dec = (ir[13:12] == 2'b01) ? OC_SHIFT : OC_OPIMM;
            7'b0110011: opc_dec = OC_OP;
            default:    opc_dec = OC_ILLEGAL;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // any state change clears the count, so it restarts on every entry to FETCH/MEM
    always_ff @(posedge clk) begin
        if (!reset)
            tmo_cnt <= '0;
        else if (state_d != state_q)
            tmo_cnt <= '0;
        else if (wait_mem)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout = wait_mem && (tmo_cnt == 8'(MEM_TIMEOUT - 1));
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            opc_q   <= OC_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                opc_q <= opc_dec;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_fetch = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        imm_sel   = 3'd7;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        halted    = 1'b0;

        // operand selects stay put from EXEC to WB so the ALU result is stable at writeback
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (opc_q)
                OC_LUI:    begin imm_sel = 3'd5; alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
                OC_AUIPC:  begin imm_sel = 3'd5; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                OC_JAL:    begin imm_sel = 3'd4; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                OC_JALR:   begin imm_sel = 3'd0; alu_b_sel = 1'b1; end
                OC_BRANCH: imm_sel = 3'd3;
                OC_LOAD,
                OC_OPIMM:  begin imm_sel = 3'd0; alu_b_sel = 1'b1; end
                OC_SHIFT:  begin imm_sel = 3'd1; alu_b_sel = 1'b1; end
                OC_STORE:  begin imm_sel = 3'd2; alu_b_sel = 1'b1; end
                default:   imm_sel = 3'd7;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = (opc_dec == OC_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (opc_q)
                    OC_BRANCH: begin
                        pc_we   = branch_taken;
                        pc_sel  = 2'd1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OC_JAL: begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd1;
                        state_d = S_WB;
                    end
                    OC_JALR: begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        state_d = S_WB;
                    end
                    OC_LOAD, OC_STORE:                       state_d = S_MEM;
                    OC_OP, OC_OPIMM, OC_SHIFT, OC_LUI, OC_AUIPC: state_d = S_WB;
                    default:                                 state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opc_q == OC_STORE);
                if (mem_ready) begin
                    if (opc_q == OC_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_we  = (ir[11:7] != 5'd0);
                wb_sel  = (opc_q == OC_LOAD) ? 2'd1 :
                          (opc_q == OC_JAL || opc_q == OC_JALR) ? 2'd2 : 2'd0;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  halted = 1'b1;
            default: state_d = S_TRAP;
        endcase

        // reset wins combinationally so an abandoned instruction never fires a strobe
        if (!reset) begin
            state_d   = S_FETCH;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_fetch = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 2'd0;
            imm_sel   = 3'd7;
            alu_a_sel = 2'd0;
            alu_b_sel = 1'b0;
            reg_we    = 1'b0;
            wb_sel    = 2'd0;
            retire    = 1'b0;
            halted    = 1'b0;
        end
    end
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_rv32i_mc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic        branch_taken;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_fetch, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire, halted;

    int checks = 0;
    int errors = 0;

    // strobe field order: {mem_req, mem_we, mem_fetch, ir_we, pc_we, reg_we, retire, halted}
    typedef struct packed {
        logic [2:0] st;
        logic [7:0] strb;
        logic [1:0] ps;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        logic [1:0] wb;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
    localparam logic [7:0] S_NONE       = 8'b0000_0000;
    localparam logic [7:0] S_FETCH_WAIT = 8'b1010_0000;
    localparam logic [7:0] S_FETCH_DONE = 8'b1011_1000;
    localparam logic [7:0] S_HALT       = 8'b0000_0001;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] SLLI  = 32'h0020_9093;
    localparam logic [31:0] LUI   = 32'h1234_50B7;
    localparam logic [31:0] AUIPC = 32'h0000_0117;
    localparam logic [31:0] ADD   = 32'h0020_81B3;
    localparam logic [31:0] JAL0  = 32'h0000_006F;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
    localparam logic [31:0] SW    = 32'h0011_2223;
    localparam logic [31:0] LW    = 32'h0001_2083;
    localparam logic [31:0] BEQ   = 32'hFE00_0EE3;
    localparam logic [31:0] ILL   = 32'hFFFF_FFFF;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .state        (state),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_fetch    (mem_fetch),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .imm_sel      (imm_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [2:0] st, input logic [7:0] s, input logic [1:0] ps,
                                input logic [2:0] im, input logic [1:0] a, input logic b,
                                input logic [1:0] wb);
        return {st, s, ps, im, a, b, wb};
    endfunction

    // one clock period: drive inputs after the rising edge, compare at the falling edge
    task automatic cyc(input logic rst, input logic [31:0] ins, input logic rdy, input logic bt,
                       input exp_t e, input string tag);
        exp_t obs, want;
        reset        = rst;
        ir           = ins;
        mem_ready    = rdy;
        branch_taken = bt;
        sb.push_back(e);
        @(negedge clk);
        obs  = {state, {mem_req, mem_we, mem_fetch, ir_we, pc_we, reg_we, retire, halted},
                pc_sel, imm_sel, alu_a_sel, alu_b_sel, wb_sel};
        want = sb.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    // zero-wait four-cycle instruction: FETCH, DECODE, EXEC, WB
    task automatic run4(input logic [31:0] ins, input logic [2:0] im, input logic [1:0] a,
                        input logic b, input logic pcwe, input logic [1:0] ps,
                        input logic [1:0] wb, input logic rdnz, input string nm);
        cyc(1'b1, ins, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), {nm, "_fetch"});
        cyc(1'b1, ins, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), {nm, "_decode"});
        cyc(1'b1, ins, 1'b1, 1'b0, ex(E, {4'b0, pcwe, 3'b000}, ps, im, a, b, 2'd0), {nm, "_exec"});
        cyc(1'b1, ins, 1'b1, 1'b0, ex(W, {5'b0, rdnz, 2'b10}, 2'd0, im, a, b, wb), {nm, "_wb"});
    endtask

    initial begin
        cyc(1'b0, ADDI, 1'b1, 1'b0, ex(F, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "reset0");
        cyc(1'b0, ADDI, 1'b1, 1'b0, ex(F, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "reset1");

        run4(ADDI,  3'd0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, "addi");
        run4(SLLI,  3'd1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, "slli");
        run4(LUI,   3'd5, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, "lui");
        run4(AUIPC, 3'd5, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, "auipc");
        run4(ADD,   3'd7, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, "add");
        run4(JAL0,  3'd4, 2'd1, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, "jal_x0");
        run4(JALR,  3'd0, 2'd0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, "jalr");

        // store with three memory wait cycles
        cyc(1'b1, SW, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "sw_fetch");
        cyc(1'b1, SW, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "sw_decode");
        cyc(1'b1, SW, 1'b0, 1'b0, ex(E, S_NONE, 2'd0, 3'd2, 2'd0, 1'b1, 2'd0), "sw_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, SW, 1'b0, 1'b0, ex(M, 8'b1100_0000, 2'd0, 3'd2, 2'd0, 1'b1, 2'd0), "sw_mem_wait");
        cyc(1'b1, SW, 1'b1, 1'b0, ex(M, 8'b1100_0010, 2'd0, 3'd2, 2'd0, 1'b1, 2'd0), "sw_mem_done");

        // branch taken, then not taken
        cyc(1'b1, BEQ, 1'b1, 1'b1, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "beq_t_fetch");
        cyc(1'b1, BEQ, 1'b1, 1'b1, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "beq_t_decode");
        cyc(1'b1, BEQ, 1'b1, 1'b1, ex(E, 8'b0000_1010, 2'd1, 3'd3, 2'd0, 1'b0, 2'd0), "beq_t_exec");
        cyc(1'b1, BEQ, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "beq_n_fetch");
        cyc(1'b1, BEQ, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "beq_n_decode");
        cyc(1'b1, BEQ, 1'b1, 1'b0, ex(E, 8'b0000_0010, 2'd1, 3'd3, 2'd0, 1'b0, 2'd0), "beq_n_exec");

        // load with one wait, full writeback
        cyc(1'b1, LW, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lw_fetch");
        cyc(1'b1, LW, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lw_decode");
        cyc(1'b1, LW, 1'b0, 1'b0, ex(E, S_NONE, 2'd0, 3'd0, 2'd0, 1'b1, 2'd0), "lw_exec");
        cyc(1'b1, LW, 1'b0, 1'b0, ex(M, 8'b1000_0000, 2'd0, 3'd0, 2'd0, 1'b1, 2'd0), "lw_mem_wait");
        cyc(1'b1, LW, 1'b1, 1'b0, ex(M, 8'b1000_0000, 2'd0, 3'd0, 2'd0, 1'b1, 2'd0), "lw_mem_done");
        cyc(1'b1, LW, 1'b1, 1'b0, ex(W, 8'b0000_0110, 2'd0, 3'd0, 2'd0, 1'b1, 2'd1), "lw_wb");

        // load abandoned by reset while in MEM
        cyc(1'b1, LW, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lwr_fetch");
        cyc(1'b1, LW, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lwr_decode");
        cyc(1'b1, LW, 1'b0, 1'b0, ex(E, S_NONE, 2'd0, 3'd0, 2'd0, 1'b1, 2'd0), "lwr_exec");
        cyc(1'b1, LW, 1'b0, 1'b0, ex(M, 8'b1000_0000, 2'd0, 3'd0, 2'd0, 1'b1, 2'd0), "lwr_mem");
        cyc(1'b0, LW, 1'b1, 1'b0, ex(M, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lwr_reset");
        cyc(1'b1, LW, 1'b0, 1'b0, ex(F, S_FETCH_WAIT, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "lwr_refetch");

        // illegal opcode traps and stays halted until reset
        cyc(1'b1, ILL, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "ill_fetch");
        cyc(1'b1, ILL, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "ill_decode");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, ILL, i[0], 1'b1, ex(T, S_HALT, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "trap_hold");
        cyc(1'b0, ILL, 1'b1, 1'b0, ex(T, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "trap_reset");

        // instruction-fetch wait: unbounded by default, traps after four waits with the timeout
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            cyc(1'b1, ADDI, 1'b0, 1'b0, ex(F, S_FETCH_WAIT, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "tmo_wait");
        cyc(1'b1, ADDI, 1'b1, 1'b0, ex(T, S_HALT, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "tmo_trap");
`else
        for (int i = 0; i < 6; i++)
            cyc(1'b1, ADDI, 1'b0, 1'b0, ex(F, S_FETCH_WAIT, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "fetch_wait");
        cyc(1'b1, ADDI, 1'b1, 1'b0, ex(F, S_FETCH_DONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "fetch_late");
        cyc(1'b1, ADDI, 1'b1, 1'b0, ex(D, S_NONE, 2'd0, 3'd7, 2'd0, 1'b0, 2'd0), "late_decode");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences FETCH/DECODE/EXEC/MEM/WB over the shared single-port memory, PC, IR, ALU and register file.
- Drives the immediate-format select into the immediate extender, so exactly one extended immediate feeds the ALU/PC adder per instruction.
- Detects illegal opcodes and halts in TRAP.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready in FETCH/MEM (used only with MEM_TIMEOUT_EN); 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
ir  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory completes current request this cycle
branch_taken  in  1  ALU branch compare result, valid in EXEC
state  out  3  FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
mem_req  out  1  memory request
mem_we  out  1  store request (only with mem_req)
mem_fetch  out  1  address source is PC (1) or ALU result (0)
ir_we  out  1  load IR and OLDPC from fetched word/PC
pc_we  out  1  PC write strobe
pc_sel  out  2  0=PC+4, 1=OLDPC+imm, 2=ALU result with bit0 cleared
imm_sel  out  3  0=I, 1=shamt, 2=S, 3=B, 4=J, 5=U, 7=none
alu_a_sel  out  2  0=rs1, 1=OLDPC, 2=zero
alu_b_sel  out  1  0=rs2, 1=selected immediate
reg_we  out  1  register-file write strobe
wb_sel  out  2  0=ALU, 1=memory data, 2=OLDPC+4
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  high in TRAP

Behaviour:
- Reset (reset low at rising clk):
  - Next state FETCH; latched opclass = NONE; timeout counter = 0.
  - While reset is low, all strobes (mem_req, mem_we, ir_we, pc_we, reg_we, retire) are forced 0 combinationally; halted=0; imm_sel=7; selects=0.
- Reset asserted mid-operation abandons the instruction. No write strobe fires in that cycle.
- Outputs are decoded combinationally from state plus an opclass register latched in DECODE. ir must stay stable from DECODE through WB.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011. Any other opcode is illegal.
- imm_sel by class:
  - OPIMM with funct3 001/101 -> 1; other OPIMM, LOAD, JALR -> 0.
  - STORE -> 2; BRANCH -> 3; JAL -> 4; LUI/AUIPC -> 5; OP -> 7.
- FETCH:
  - mem_req=1, mem_fetch=1.
  - Hold until mem_ready=1; in that cycle ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
- DECODE: one cycle; latch opclass. Illegal -> TRAP; else EXEC.
- EXEC: one cycle.
  - BRANCH: pc_we=branch_taken, pc_sel=1; retire=1; -> FETCH.
  - JAL: pc_we=1, pc_sel=1; -> WB.
  - JALR: pc_we=1, pc_sel=2; -> WB.
  - LOAD/STORE: alu_b_sel=1; -> MEM.
  - OP/OPIMM/LUI/AUIPC -> WB. LUI uses alu_a_sel=2; AUIPC uses alu_a_sel=1.
- MEM:
  - mem_req=1, mem_fetch=0, mem_we=1 for STORE.
  - Request and address held until mem_ready=1.
  - On mem_ready: STORE -> FETCH with retire=1; LOAD -> WB.
- WB:
  - reg_we=1 iff ir[11:7] != 0.
  - wb_sel: LOAD=1, JAL/JALR=2, else 0.
  - retire=1; -> FETCH.
- TRAP: all strobes 0, halted=1, sticky until reset.
- mem_ready is ignored outside FETCH/MEM.
- Latency with zero-wait memory: OP/OPIMM/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each wait cycle adds 1.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When the count reaches MEM_TIMEOUT without mem_ready, the next state is TRAP; no ir_we or pc_we occurs.
  - mem_ready in the same cycle the limit is reached wins (normal completion).
- Undefined: no counter; waits indefinitely.

Test Plan:
- Reset low 2 cycles, release, mem_ready=1, ir=0x00500093 (addi x1,x0,5) -> states 0,1,2,4,0; imm_sel=0, alu_b_sel=1, reg_we=1 in WB, retire pulses once in cycle 4.
- ir=0x00112223 (sw), mem_ready low 3 cycles in MEM -> mem_req=mem_we=1 held 4 cycles, no reg_we, retire on the mem_ready cycle, imm_sel=2.
- ir=0xFE000EE3 (beq) with branch_taken=1 then 0 -> imm_sel=3, pc_we=1/pc_sel=1 in EXEC only when taken, back to FETCH after 3 cycles.
- ir=0x0000006F (jal x0) -> imm_sel=4, pc_sel=1 in EXEC, reg_we=0 in WB (rd=0), wb_sel=2.
- ir=0xFFFFFFFF -> DECODE->TRAP, halted=1, mem_req stays 0 for 10 cycles; reset low then returns to FETCH.
- Reset asserted during MEM of a load -> next cycle state=FETCH, no reg_we. With MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles.
